rca_pipe_sched: RTL and testbench
=================================

Name: rca_pipe_sched

Overview:
- Shares one 4-bit pipelined ripple-carry adder (4 register stages, no stall, no reset inside the adder) between NREQ requesters.
- Per cycle: round-robin selects at most one valid request and drives its operands into the adder, or drives a bubble (all zeros).
- A tag pipeline that matches the adder latency carries valid and requester ID, so each result returns with the ID of its issuer.
- A flush FSM stops issue and reports when the adder pipeline is empty.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/sum width; must match the adder.
- LAT, 4, adder latency in clock edges. The operand-capture edge counts as edge 1.
- IDW, 3, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing as req_a.
- req_cin  in  NREQ  per-requester carry-in.
- req_ready  out  NREQ  one-hot grant; accept = req_valid[i] & req_ready[i].
- add_a  out  WIDTH  operand A to adder.
- add_b  out  WIDTH  operand B to adder.
- add_cin  out  1  carry-in to adder.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid, one-cycle pulse.
- rsp_id  out  IDW  requester that issued this result.
- rsp_sum  out  WIDTH  result sum, equal to add_sum.
- rsp_cout  out  1  result carry-out, equal to add_cout.
- flush  in  1  request to stop issue and drain.
- flush_done  out  1  high while in FLUSHED state.
- busy  out  1  high when any tag stage is valid.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - rr_ptr = 0; FSM = RUN; all tag stages cleared.
  - Outputs: req_ready = 0, add_a/add_b/add_cin = 0, rsp_valid = 0, rsp_id = 0, flush_done = 0, busy = 0.
- Arbitration (combinational, RUN state only):
  - Search req_valid starting at index rr_ptr, wrapping; the first set bit wins.
  - req_ready is one-hot on the winner, or all zero when no request is valid.
  - Operands of the winner drive add_a/add_b/add_cin in the same cycle.
  - With no winner, add_* = 0 (bubble).
- On an accepting edge: rr_ptr <= (winner+1) mod NREQ. With no grant, rr_ptr holds.
- Requesters hold valid and operands until accepted; req_ready does not depend on any previous-cycle acceptance.
- Full throughput: one issue per cycle, no idle cycle between back-to-back grants.
- Tag pipeline:
  - LAT stages of {v, id}.
  - Stage0 <= {accept, winner id} on every edge; stage k <= stage k-1.
  - rsp_valid = stage[LAT-1].v and rsp_id = stage[LAT-1].id.
  - A request accepted at edge n gives rsp_valid high during the cycle after edge n+LAT-1, with rsp_sum = add_sum.
  - rsp_id is 0 when rsp_valid is 0.
- busy = OR of all stage v bits.
- Flush FSM, states RUN, DRAIN, FLUSHED:
  - RUN -> DRAIN when flush = 1. In the same cycle req_ready is forced to 0 (flush wins over a grant).
  - DRAIN: no grants. DRAIN -> FLUSHED when busy = 0.
  - FLUSHED: flush_done = 1, no grants. FLUSHED -> RUN when flush = 0.
  - If flush drops while in DRAIN, stay in DRAIN until empty, then go through FLUSHED for one cycle.
  - Flush asserted when already empty: RUN -> DRAIN -> FLUSHED, minimum 2 edges.
- Reset mid-operation:
  - In-flight tags are discarded; no rsp_valid is produced for them.
  - Adder registers are not reset; their garbage is never flagged valid.
- Arithmetic: this block performs none. The result width is WIDTH+1 ({cout, sum}).

Optional Feature:
- Macro: RCA_SCHED_STATS_EN.
- Defined:
  - Adds output grant_cnt (NREQ*16): a per-requester 16-bit saturating accept counter, reset to 0, saturating at 16'hFFFF.
  - Adds input stats_clr (1): synchronous clear; a clear in the same cycle as an accept yields 0.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package rca_sched_pkg:
  - state enum {RUN, DRAIN, FLUSHED};
  - tag struct {logic v; logic [IDW-1:0] id};
  - localparam default LAT = 4.
- One sub-module, rr_arbiter: NREQ-wide rotating-priority one-hot grant from req and ptr, purely combinational. The pointer register lives in the parent.

Test Plan:
- Single issue: req0 with a=7, b=5, cin=0, accepted at edge n -> single rsp_valid pulse after edge n+3; rsp_id=0, sum=12, cout=0; busy falls afterwards.
- Carry-out: req2 with a=10, b=6, cin=0 -> rsp_id=2, sum=0, cout=1. Then req1 with a=4, b=10, cin=1 -> rsp_id=1, sum=15, cout=0.
- Contention: from reset, req0..3 all valid and held -> grants in order 0,1,2,3,0 on consecutive edges; responses return in the same order with no gaps; rr_ptr wraps.
- Flush: three back-to-back issues, then flush=1 -> req_ready=0 in that cycle; all three responses still delivered; flush_done rises the cycle after busy falls; flush=0 -> grants resume from rr_ptr.
- Reset mid-flight: three in flight, pulse Rst_n low for 3 ns asynchronously -> all outputs 0 immediately; no rsp_valid for 6 cycles after release.
- Stats (RCA_SCHED_STATS_EN defined): 5 accepts for req1 -> grant_cnt[31:16]=5; stats_clr concurrent with an accept -> 0.

Source files
------------

// File: rtl/rca_sched_pkg.sv
// Shared types for the rca_pipe_sched adder scheduler: flush FSM states,
// the in-flight tag carried alongside the adder pipeline, and default sizes.
package rca_sched_pkg;

  // Default adder latency in clock edges; the operand-capture edge is edge 1.
  localparam int LAT_DEF = 4;

  // Tag ID width; 3 bits cover up to 8 requesters.
  localparam int TAG_IDW = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } state_t;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [TAG_IDW-1:0] wrap_inc(input logic [TAG_IDW-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rca_pipe_sched_arb.sv
// rr_arbiter: rotating-priority one-hot grant. Priority starts at i_ptr and
// wraps; the lowest rotated index with a request wins. Purely combinational,
// the pointer register is owned by the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_id,
  output logic            o_any
);

  logic [2*NREQ-1:0] w_dbl;
  int                w_off;
  int                w_win;

  // Rotate the request vector so the pointer lands on bit 0, then pick the first set bit.
  always_comb begin
    w_dbl = {i_req, i_req} >> i_ptr;
    w_off = 0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && w_dbl[k]) begin
        o_any = 1'b1;
        w_off = k;
      end
    end
    w_win = int'(i_ptr) + w_off;
    if (w_win >= NREQ) w_win = w_win - NREQ;
    o_gnt_id = o_any ? IDW'(w_win) : '0;
    o_gnt    = '0;
    for (int j = 0; j < NREQ; j++) begin
      o_gnt[j] = o_any && (w_win == j);
    end
  end

endmodule

// File: rtl/rca_pipe_sched.sv
// rca_pipe_sched: shares one pipelined ripple-carry adder between NREQ
// requesters. A round-robin arbiter issues at most one operand set per cycle,
// a tag pipeline matching the adder latency returns each result with the ID
// of its issuer, and a flush FSM stops issue and reports when the adder is empty.
// Optional build macro: RCA_SCHED_STATS_EN adds per-requester saturating
// accept counters (grant_cnt) with a synchronous clear (stats_clr).
// IDW must equal rca_sched_pkg::TAG_IDW.
//
//   state   | meaning
//   RUN     | arbitration enabled, one issue per cycle
//   DRAIN   | issue stopped, waiting for the tag pipeline to empty
//   FLUSHED | pipeline empty, flush_done high until flush drops
module rca_pipe_sched
  import rca_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int LAT   = LAT_DEF,
  parameter int IDW   = TAG_IDW
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
  output logic [NREQ-1:0]    req_ready,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_cout,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy
`ifdef RCA_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt,
  input  logic               stats_clr
`endif
);

  state_t          r_state;
  logic            r_flush_done;
  logic [IDW-1:0]  r_rr_ptr;
  logic            r_live;
  tag_t            r_tag [LAT];

  logic            w_issue_en;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_gnt_any;
  logic            w_busy;

  // Grants only in RUN, never in the cycle flush is raised, and not before
  // the first edge after reset so req_ready stays low throughout reset.
  assign w_issue_en = r_live && (r_state == RUN) && !flush;
  assign w_elig     = req_valid & {NREQ{w_issue_en}};

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req    (w_elig),
    .i_ptr    (r_rr_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_gnt_any)
  );

  assign req_ready = w_gnt;

  // Operand mux: winner's operands, or an all-zero bubble when nothing is granted.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        add_a   = req_a[i*WIDTH +: WIDTH];
        add_b   = req_b[i*WIDTH +: WIDTH];
        add_cin = req_cin[i];
      end
    end
  end

  // Pointer moves past the winner on each accept; r_live opens issue one edge after reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rr_ptr <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_gnt_any) r_rr_ptr <= wrap_inc(w_gnt_id, NREQ);
    end
  end

  // Tag pipeline shadows the adder stages; an idle slot carries id 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].v  <= w_gnt_any;
      r_tag[0].id <= w_gnt_any ? w_gnt_id : '0;
      for (int k = 1; k < LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Busy whenever any stage holds a live tag.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < LAT; k++) w_busy = w_busy | r_tag[k].v;
  end

  assign busy      = w_busy;
  assign rsp_valid = r_tag[LAT-1].v;
  assign rsp_id    = r_tag[LAT-1].id;
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;

  // Flush FSM with registered flush_done.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= RUN;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (flush) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_busy) begin
            r_state      <= FLUSHED;
            r_flush_done <= 1'b1;
          end
        end
        FLUSHED: begin
          if (!flush) begin
            r_state      <= RUN;
            r_flush_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= RUN;
          r_flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign flush_done = r_flush_done;

`ifdef RCA_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] r_grant_cnt;

  // Per-requester saturating accept counters; clear beats a same-cycle accept.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stats_clr) r_grant_cnt[i] <= '0;
        else if (w_gnt[i] && (r_grant_cnt[i] != 16'hFFFF)) r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_rca_pipe_sched.sv
// Bench for rca_pipe_sched: a behavioural 4-stage adder, per-requester
// operand queues, and a reference model that predicts grants, operands,
// busy/flush_done and pushes expected responses into a scoreboard.
module tb_rca_pipe_sched;
  import rca_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int LAT   = 4;
  localparam int IDW   = 3;

  logic                  Clk = 1'b0;
  logic                  Rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_cin = '0;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      add_a, add_b, add_sum;
  logic                  add_cin, add_cout;
  logic                  rsp_valid, rsp_cout;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  flush = 1'b0;
  logic                  flush_done, busy;
`ifdef RCA_SCHED_STATS_EN
  logic [NREQ*16-1:0]    grant_cnt;
  logic                  stats_clr = 1'b0;
  int                    m_cnt [NREQ];
`endif

  always #5 Clk = ~Clk;

  rca_pipe_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef RCA_SCHED_STATS_EN
    , .grant_cnt(grant_cnt), .stats_clr(stats_clr)
`endif
  );

  // Behavioural pipelined adder, no reset.
  logic [WIDTH:0] s1, s2, s3, s4;
  always @(posedge Clk) begin
    s1 <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    s2 <= s1;
    s3 <= s2;
    s4 <= s3;
  end
  assign add_sum  = s4[WIDTH-1:0];
  assign add_cout = s4[WIDTH];

  typedef struct { logic [3:0] a; logic [3:0] b; logic cin; } op_t;
  typedef struct { int id; logic [4:0] s; int cyc; } exp_t;

  op_t        opq [NREQ][$];
  exp_t       sb [$];
  int         n_chk = 0, n_pass = 0, n_acc = 0, cyc = 0, m_ptr = 0;
  bit         m_live = 0, m_busy_cur = 0;
  state_t     m_state = RUN;
  logic [NREQ-1:0] acc_s = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_win(input logic [NREQ-1:0] v, input int ptr, input bit en);
    if (!en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
    end
    return -1;
  endfunction

  function automatic op_t op_of(input int w);
    op_t o;
    o.a   = 4'(req_a >> (w * WIDTH));
    o.b   = 4'(req_b >> (w * WIDTH));
    o.cin = 1'(req_cin >> w);
    return o;
  endfunction

  // Reference model: advances on each edge, pushes expected responses.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_ptr = 0; m_state = RUN; m_live = 0; m_busy_cur = 0;
      sb.delete();
`ifdef RCA_SCHED_STATS_EN
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`endif
    end else begin
      int w;
      op_t o;
      exp_t e;
      cyc++;
      w = exp_win(req_valid, m_ptr, m_live && (m_state == RUN) && !flush);
      if (w >= 0) begin
        o = op_of(w);
        e.id = w;
        e.s = {1'b0, o.a} + {1'b0, o.b} + {4'b0, o.cin};
        e.cyc = cyc;
        sb.push_back(e);
        m_ptr = (w + 1) % NREQ;
        n_acc++;
      end
`ifdef RCA_SCHED_STATS_EN
      if (stats_clr) for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      else if (w >= 0 && m_cnt[w] != 65535) m_cnt[w]++;
`endif
      case (m_state)
        RUN:     if (flush) m_state = DRAIN;
        DRAIN:   if (!m_busy_cur) m_state = FLUSHED;
        FLUSHED: if (!flush) m_state = RUN;
        default: m_state = RUN;
      endcase
      m_live = 1;
    end
  end

  // Monitor: compares DUT outputs mid-cycle and drains the scoreboard.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_cin", add_cin, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_busy", busy, 0);
    end else begin
      int w;
      op_t o;
      exp_t e;
      w = exp_win(req_valid, m_ptr, m_live && (m_state == RUN) && !flush);
      o = op_of(w < 0 ? 0 : w);
      chk("grant", req_ready, w >= 0 ? (32'd1 << w) : 32'd0);
      chk("add_a", add_a, w >= 0 ? o.a : 4'd0);
      chk("add_b", add_b, w >= 0 ? o.b : 4'd0);
      chk("add_cin", add_cin, w >= 0 ? o.cin : 1'b0);
      chk("flush_done", flush_done, m_state == FLUSHED);
      m_busy_cur = (sb.size() != 0);
      chk("busy", busy, m_busy_cur);
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_sum", rsp_sum, e.s[3:0]);
          chk("rsp_cout", rsp_cout, e.s[4]);
          chk("rsp_lat", cyc - e.cyc, LAT - 1);
        end
      end else begin
        chk("rsp_id_idle", rsp_id, 0);
        if (sb.size() != 0 && (cyc - sb[0].cyc) >= LAT - 1) begin
          chk("rsp_missing", rsp_valid, 1);
          void'(sb.pop_front());
        end
      end
`ifdef RCA_SCHED_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), m_cnt[i]);
`endif
      acc_s = req_valid & req_ready;
    end
  end

  // Requester driver: hold valid until accepted, then present the next queued op.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_s[i] || !req_valid[i]) begin
          if (opq[i].size() > 0) begin
            op_t o;
            o = opq[i].pop_front();
            req_valid[i] = 1'b1;
            req_a[i*WIDTH +: WIDTH] = o.a;
            req_b[i*WIDTH +: WIDTH] = o.b;
            req_cin[i] = o.cin;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      acc_s = '0;
    end
  end

  task automatic push(input int i, input logic [3:0] a, input logic [3:0] b, input logic cin);
    op_t o;
    o.a = a; o.b = b; o.cin = cin;
    opq[i].push_back(o);
  endtask

  task automatic wait_idle();
    int t = 0;
    bit ok = 0;
    while (!ok && t < 300) begin
      @(negedge Clk);
      #1;
      t++;
      ok = (req_valid == 0) && (sb.size() == 0) && !busy;
      for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) ok = 0;
    end
    chk("idle_reached", ok, 1);
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    int target;
    target = n_acc + n;
    while (n_acc < target && t < 100) begin
      @(posedge Clk);
      #1;
      t++;
    end
    chk("accepts_reached", n_acc >= target, 1);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #6 Rst_n = 1'b0;
    acc_s = '0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  initial begin
    #1 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (2) @(posedge Clk);

    // single issue, then carry-out and carry-in cases
    push(0, 4'd7, 4'd5, 1'b0);
    wait_idle();
    push(2, 4'd10, 4'd6, 1'b0);
    wait_idle();
    push(1, 4'd4, 4'd10, 1'b1);
    wait_idle();

    // contention from reset: expected order 0,1,2,3,0
    do_reset();
    push(0, 4'd1, 4'd2, 1'b0);
    push(0, 4'd3, 4'd3, 1'b1);
    push(1, 4'd15, 4'd1, 1'b0);
    push(2, 4'd8, 4'd8, 1'b1);
    push(3, 4'd9, 4'd6, 1'b1);
    wait_acc(5);
    wait_idle();

    // flush with a request still pending (pointer is at 1: order 1,2,3 then 0 held)
    push(0, 4'd2, 4'd2, 1'b0);
    push(1, 4'd5, 4'd9, 1'b1);
    push(2, 4'd12, 4'd7, 1'b0);
    push(3, 4'd6, 4'd6, 1'b0);
    wait_acc(3);
    flush = 1'b1;
    @(negedge Clk);
    chk("flush_blocks_ready", req_ready, 0);
    begin
      int t = 0;
      while (!flush_done && t < 50) begin
        @(negedge Clk);
        t++;
      end
    end
    chk("flush_done_seen", flush_done, 1);
    chk("flush_drained", sb.size(), 0);
    @(posedge Clk);
    #1 flush = 1'b0;
    wait_idle();

    // asynchronous reset with three results in flight
    push(0, 4'd1, 4'd1, 1'b0);
    push(1, 4'd2, 4'd2, 1'b0);
    push(2, 4'd3, 4'd3, 1'b0);
    wait_acc(3);
    #5 Rst_n = 1'b0;
    acc_s = '0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_add_a", add_a, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    #2 Rst_n = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    wait_idle();

`ifdef RCA_SCHED_STATS_EN
    @(posedge Clk);
    #1 stats_clr = 1'b1;
    @(posedge Clk);
    #1 stats_clr = 1'b0;
    for (int k = 0; k < 5; k++) push(1, 4'(k), 4'd1, 1'b0);
    wait_idle();
    chk("cnt_req1_five", grant_cnt[31:16], 5);
    push(1, 4'd6, 4'd6, 1'b0);
    @(posedge Clk);
    #2 stats_clr = 1'b1;
    wait_acc(1);
    stats_clr = 1'b0;
    @(negedge Clk);
    chk("cnt_clr_beats_accept", grant_cnt[31:16], 0);
    wait_idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
